// File: rtl/interp_ctrl_pkg.sv
// Shared types and default geometry for the interpolation loop controller.
// The optional abort input is enabled by the INTERP_CTRL_ABORT_EN macro (see interp_loop_ctrl.sv).
package interp_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default sweep geometry: 14 columns x 8 rows, 4-bit counters
    localparam int DEFAULT_CW       = 4;
    localparam int DEFAULT_LAST_COL = 13;
    localparam int DEFAULT_LAST_ROW = 7;

endpackage

// File: rtl/interp_wrap_cnt.sv
// CW-bit counter that counts 0..LAST and wraps back to 0.
// wrap_o flags the terminal value; the compare happens before the add,
// so the adder never overflows.
module interp_wrap_cnt #(
    parameter int CW   = 4,
    parameter int LAST = 13
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] LAST_V = CW'(LAST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == LAST_V);

    // Next count: clear wins, otherwise advance or wrap when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interp_loop_ctrl.sv
// Loop controller for the interpolation buffer read: sweeps columns 0..LAST_COL
// within rows 0..LAST_ROW, one read per ready cycle, then pulses done.
// Optional feature: define INTERP_CTRL_ABORT_EN to add the abort input.
module interp_loop_ctrl
    import interp_ctrl_pkg::*;
#(
    parameter int CW       = DEFAULT_CW,
    parameter int LAST_COL = DEFAULT_LAST_COL,
    parameter int LAST_ROW = DEFAULT_LAST_ROW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready_in,
`ifdef INTERP_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          rd_en,
    output logic [CW-1:0] col_sel,
    output logic [CW-1:0] row_sel,
    output logic          line_end,
    output logic          done
);

    state_e state_q;
    state_e state_d;

    logic   col_wrap;
    logic   row_wrap;
    logic   abort_req;
    logic   cnt_clr;

`ifdef INTERP_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only matters mid-sweep; it wipes the counters on its way to IDLE
    assign cnt_clr = (state_q == ST_RUN) && abort_req;

    interp_wrap_cnt #(
        .CW   (CW),
        .LAST (LAST_COL)
    ) u_col_cnt (
        .clk    (clk),
        .srst   (rst),
        .en     (rd_en),
        .clr    (cnt_clr),
        .cnt_o  (col_sel),
        .wrap_o (col_wrap)
    );

    // The row advances only when the column wraps on an issued read;
    // on the final read both counters wrap back to zero by themselves
    interp_wrap_cnt #(
        .CW   (CW),
        .LAST (LAST_ROW)
    ) u_row_cnt (
        .clk    (clk),
        .srst   (rst),
        .en     (rd_en && col_wrap),
        .clr    (cnt_clr),
        .cnt_o  (row_sel),
        .wrap_o (row_wrap)
    );

    // Next-state and output decode; ready_in -> rd_en is the only combinational path
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        rd_en    = 1'b0;
        line_end = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                line_end = col_wrap;
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en = ready_in;
                    if (ready_in && col_wrap && row_wrap) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_interp_loop_ctrl.sv
// Self-checking bench for interp_loop_ctrl: a phase table with hand-derived
// totals, hand-written corner sequences, and randomized cycles checked against
// a read-index model of the sweep.
module tb_interp_loop_ctrl;

    localparam int CW     = 4;
    localparam int LC     = 13;
    localparam int LR     = 7;
    localparam int NCOL   = LC + 1;
    localparam int NROW   = LR + 1;
    localparam int NREADS = NCOL * NROW;
`ifdef INTERP_CTRL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready_in;
    logic          abort_v;
    logic          busy;
    logic          rd_en;
    logic [CW-1:0] col_sel;
    logic [CW-1:0] row_sel;
    logic          line_end;
    logic          done;

    interp_loop_ctrl #(
        .CW       (CW),
        .LAST_COL (LC),
        .LAST_ROW (LR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready_in (ready_in),
`ifdef INTERP_CTRL_ABORT_EN
        .abort    (abort_v),
`endif
        .busy     (busy),
        .rd_en    (rd_en),
        .col_sel  (col_sel),
        .row_sel  (row_sel),
        .line_end (line_end),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int reads  = 0;
    int dones  = 0;
    int last_done_cyc = -1;
    logic last_busy;
    logic last_rd;
    logic [2*CW+3:0] last_out;

    // Model: mode 0=idle 1=running 2=done; m_n = reads already issued in this sweep
    int m_mode = 0;
    int m_n    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare against the model at negedge, advance model at posedge
    task automatic tick(input logic st, input logic rdy, input logic rs, input logic ab);
        logic [2*CW+3:0] exp_v;
        logic            e_run;
        logic            e_rd;
        logic [CW-1:0]   e_col;
        logic [CW-1:0]   e_row;
        start = st; ready_in = rdy; rst = rs; abort_v = ab;
        @(negedge clk);
        e_run = (m_mode == 1);
        e_rd  = e_run && rdy && !(ABORT_EN && ab);
        e_col = e_run ? CW'(m_n % NCOL) : '0;
        e_row = e_run ? CW'(m_n / NCOL) : '0;
        exp_v = {(m_mode != 0), e_rd, (m_mode == 2), (e_run && (m_n % NCOL == LC)), e_row, e_col};
        last_out  = {busy, rd_en, done, line_end, row_sel, col_sel};
        last_busy = busy;
        last_rd   = rd_en;
        n_chk++;
        if (last_out !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got busy/rd/done/le/row/col=%b, expected %b",
                     cyc, last_out, exp_v);
        end
        if (!rs && rd_en) reads++;
        if (done) begin
            dones++;
            last_done_cyc = cyc;
        end
        @(posedge clk);
        if (rs) begin
            m_mode = 0; m_n = 0;
        end else begin
            case (m_mode)
                0: if (st) begin m_mode = 1; m_n = 0; end
                1: begin
                    if (ABORT_EN && ab) begin
                        m_mode = 0; m_n = 0;
                    end else if (rdy) begin
                        m_n++;
                        if (m_n == NREADS) begin m_mode = 2; m_n = 0; end
                    end
                end
                default: m_mode = 0;
            endcase
        end
        cyc++;
        #1;
    endtask

    // Advance with ready high until the counters show (row, col); bounded
    task automatic run_to(input int row, input int col, input string name);
        int guard = 0;
        while (!(int'(row_sel) == row && int'(col_sel) == col) && guard < 300) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check({name, "_reach_timeout"}, (guard < 300) ? 1 : 0, 1);
    endtask

    typedef struct {
        string name;
        logic  rs;
        logic  st;
        logic  rdy;
        int    ncyc;
        int    exp_reads;
        int    exp_dones;
        logic  exp_busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t0;
        int guard;
        vecs[0] = '{"reset",        1'b1, 1'b0, 1'b1,   2,   0, 0, 1'b0};
        vecs[1] = '{"idle10",       1'b0, 1'b0, 1'b1,  10,   0, 0, 1'b0};
        vecs[2] = '{"sweep",        1'b0, 1'b1, 1'b1, 113, 112, 0, 1'b1};
        vecs[3] = '{"done_cycle",   1'b0, 1'b0, 1'b1,   1,   0, 1, 1'b1};
        vecs[4] = '{"back_idle",    1'b0, 1'b0, 1'b1,   3,   0, 0, 1'b0};
        vecs[5] = '{"start_stall",  1'b0, 1'b1, 1'b0,  20,   0, 0, 1'b1};
        vecs[6] = '{"resume",       1'b0, 1'b0, 1'b1, 113, 112, 1, 1'b1};
        vecs[7] = '{"idle_after",   1'b0, 1'b0, 1'b1,   2,   0, 0, 1'b0};

        // Bring the DUT out of its unknown power-up state before checking
        rst = 1'b1; start = 1'b0; ready_in = 1'b0; abort_v = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            reads = 0; dones = 0;
            for (int i = 0; i < vecs[v].ncyc; i++) begin
                tick((i == 0) ? vecs[v].st : 1'b0, vecs[v].rdy, vecs[v].rs, 1'b0);
            end
            check({vecs[v].name, "_reads"}, reads, vecs[v].exp_reads);
            check({vecs[v].name, "_dones"}, dones, vecs[v].exp_dones);
            check({vecs[v].name, "_busy"}, int'(last_busy), int'(vecs[v].exp_busy));
            $display("vector %0d %s: reads=%0d dones=%0d busy=%0d", v, vecs[v].name, reads, dones, last_busy);
        end

        // Stall for 3 cycles at row 2, col 5: done moves from 113 to 116
        reads = 0; dones = 0; last_done_cyc = -1;
        t0 = cyc;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        run_to(2, 5, "stall");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_rd_en", int'(last_rd), 0);
            check("stall_col", int'(col_sel), 5);
            check("stall_row", int'(row_sel), 2);
        end
        guard = 0;
        while (last_done_cyc < 0 && guard < 300) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check("stall_done_timeout", (guard < 300) ? 1 : 0, 1);
        check("stall_done_cycle", last_done_cyc - t0, 116);
        check("stall_reads", reads, NREADS);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        $display("sequence stall: reads=%0d done at +%0d", reads, last_done_cyc - t0);

        // Starts at 0, 40 and 113 give one sweep; a start at 114 begins the next
        reads = 0; dones = 0;
        for (int i = 0; i <= 113; i++) begin
            tick((i == 0 || i == 40 || i == 113) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_busy_114", int'(last_busy), 0);
        check("restart_reads", reads, NREADS);
        check("restart_dones", dones, 1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_busy_115", int'(last_busy), 1);
        check("restart_rd_115", int'(last_rd), 1);
        guard = 0;
        while (last_busy && guard < 300) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check("restart_drain_timeout", (guard < 300) ? 1 : 0, 1);
        $display("sequence start_while_busy: reads=%0d dones=%0d", reads, dones);

        // Reset mid-sweep at row 4, col 9
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        run_to(4, 9, "midrst");
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_outputs_zero", int'(last_out), 0);
        dones = 0;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_no_done", dones, 0);
        reads = 0;
        for (int i = 0; i < 115; i++) tick((i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_full_reads", reads, NREADS);
        check("midrst_full_dones", dones, 1);
        $display("sequence reset_mid_sweep: reads=%0d dones=%0d", reads, dones);

`ifdef INTERP_CTRL_ABORT_EN
        // Abort after 50 reads: nothing further issued and no done
        reads = 0; dones = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (reads < 50 && guard < 200) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("abort_rd_gated", int'(last_rd), 0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_idle", int'(last_busy), 0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_reads", reads, 50);
        check("abort_dones", dones, 0);
        // Abort together with reset behaves as reset
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_rst_zero", int'(last_out), 0);
        $display("sequence abort: reads=%0d dones=%0d", reads, dones);
`endif

        // Randomized traffic against the model
        reads = 0; dones = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end
        $display("sequence random: 3000 cycles, reads=%0d dones=%0d", reads, dones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
